arith_seq_controller: RTL

ARITH_SEQ_CONTROLLER -- requirements
Module: arith_seq_controller

---
 rtl/arith_seq_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/arith_seq_controller.sv
// Micro-sequencer for the AND / left-shift / shift-add multiply datapath.
// Every strobe is decoded from registered state; do_sum additionally gates on reg_c_30.
module arith_seq_controller #(
  parameter int CNT_W     = 5,
  parameter int MUL_STEPS = 30,
  parameter bit SHIFT_C29 = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [CNT_W-1:0] shift_amt,
  input  logic             reg_c_30,
  output logic             busy,
  output logic             finish,
  output logic             do_and,
  output logic             do_move_c_to_b,
  output logic             do_left_shift_c,
  output logic             do_left_shift_c29,
  output logic             do_clear_b,
  output logic             do_sum,
  output logic             do_right_shift_bc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AND0,
    S_AND1,
    S_SHL,
    S_MUL_CLR,
    S_MUL_ADD,
    S_MUL_SHR,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NULL = 3'd0,
    OP_AND  = 3'd1,
    OP_SHL  = 3'd2,
    OP_MUL  = 3'd3
  } op_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= OP_NULL;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (operation)
              3'd1: begin
                op_q  <= OP_AND;
                state <= S_AND0;
              end
              3'd2: begin
                op_q  <= OP_SHL;
                cnt   <= shift_amt;
                state <= S_SHL;
              end
              3'd3: begin
                op_q  <= OP_MUL;
                state <= S_MUL_CLR;
              end
              default: ;
            endcase
          end
        end
        S_AND0: state <= S_AND1;
        S_AND1: state <= S_DONE;
        S_SHL: begin
          // Test before decrement so a full-scale count never wraps.
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - CNT_ONE;
        end
        S_MUL_CLR: begin
          cnt   <= MUL_LOAD;
          state <= S_MUL_ADD;
        end
        S_MUL_ADD: state <= S_MUL_SHR;
        S_MUL_SHR: begin
          cnt   <= cnt - CNT_ONE;
          state <= (cnt == CNT_ONE) ? S_DONE : S_MUL_ADD;
        end
        S_DONE: begin
          op_q  <= OP_NULL;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy              = 1'b0;
    finish            = 1'b0;
    do_and            = 1'b0;
    do_move_c_to_b    = 1'b0;
    do_left_shift_c   = 1'b0;
    do_left_shift_c29 = 1'b0;
    do_clear_b        = 1'b0;
    do_sum            = 1'b0;
    do_right_shift_bc = 1'b0;
    busy   = (state != S_IDLE);
    finish = (state == S_DONE);
    case (state)
      S_AND0:    do_and         = (op_q == OP_AND);
      S_AND1:    do_move_c_to_b = (op_q == OP_AND);
      S_SHL: begin
        do_left_shift_c   = (op_q == OP_SHL) && (cnt != '0);
        do_left_shift_c29 = SHIFT_C29 && (op_q == OP_SHL) && (cnt != '0);
      end
      S_MUL_CLR: do_clear_b        = (op_q == OP_MUL);
      S_MUL_ADD: do_sum            = (op_q == OP_MUL) && reg_c_30;
      S_MUL_SHR: do_right_shift_bc = (op_q == OP_MUL);
      default: ;
    endcase
  end

endmodule
